// File: rtl/power_seq_pkg.sv
// Shared types and defaults for the multi-rail supply sequencer.
package power_seq_pkg;

    typedef enum logic [2:0] {
        OFF,
        RAMP_UP,
        GAP,
        ON,
        RAMP_DN,
        FAULT
    } seq_state_t;

    localparam real RON_DEFAULT     = 0.1;
    localparam real ROFF_DEFAULT    = 10e3;
    localparam real PG_FRAC_DEFAULT = 0.9;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/DE_thevenin.sv
// Thevenin source (vdrv behind rdrv) feeding a resistive load to ground;
// reports the resolved node voltage and the current into the load.
module DE_thevenin (
    input  real vdrv,
    input  real rdrv,
    input  real rload,
    output real vobs,
    output real iobs
);

    always_comb begin
        iobs = vdrv / (rdrv + rload);
        vobs = iobs * rload;
    end

endmodule

// File: rtl/power_seq_rail.sv
// One supply rail: step counter, ramped Thevenin drive, overcurrent
// filter and registered power-good.
module power_seq_rail
    import power_seq_pkg::*;
#(
    parameter int unsigned RAMP_STEPS = 16,
    parameter real         RON        = RON_DEFAULT,
    parameter real         ROFF       = ROFF_DEFAULT,
    parameter real         PG_FRAC    = PG_FRAC_DEFAULT,
    localparam int unsigned S_W       = clog2_min1(RAMP_STEPS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up,
    input  logic           down,
    input  logic           clr,
    input  real            vset,
    input  real            ilim,
    input  real            rload,
    output real            vout,
    output logic [S_W-1:0] step,
    output logic           pgood,
    output logic           oc_trip_c
);

    localparam logic [S_W-1:0] FULL = S_W'(RAMP_STEPS);

    real  vdrv;
    real  rdrv;
    real  iobs;
    real  iabs;
    logic full_c;
    logic oc_now_c;
    logic oc_q;

    // Drive follows the step register directly, so reset drops it at once.
    always_comb begin
        vdrv = vset * real'(step) / real'(RAMP_STEPS);
        rdrv = (step != '0) ? RON : ROFF;
    end

    DE_thevenin u_drv (
        .vdrv  (vdrv),
        .rdrv  (rdrv),
        .rload (rload),
        .vobs  (vout),
        .iobs  (iobs)
    );

    always_comb begin
        iabs      = (iobs < 0.0) ? -iobs : iobs;
        full_c    = (step == FULL);
        oc_now_c  = (step != '0) && (iabs > ilim);
        oc_trip_c = oc_now_c && oc_q;
    end

    // pgood falls on the edge that starts the step-down, not one later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step  <= '0;
            oc_q  <= 1'b0;
            pgood <= 1'b0;
        end else begin
            if (clr) begin
                step <= '0;
            end else if (up && !full_c) begin
                step <= step + S_W'(1);
            end else if (down && (step != '0)) begin
                step <= step - S_W'(1);
            end
            oc_q  <= oc_now_c && !clr;
            pgood <= full_c && !down && !clr && (vout >= PG_FRAC * vset);
        end
    end

endmodule

// File: rtl/power_seq_adrive.sv
// Multi-rail supply sequencer: ramps rails up in channel order with a gap,
// down in reverse order, and drops every rail on a filtered overcurrent.
module power_seq_adrive
    import power_seq_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned RAMP_STEPS = 16,
    parameter int unsigned SEQ_GAP    = 8,
    parameter real         RON        = RON_DEFAULT,
    parameter real         ROFF       = ROFF_DEFAULT,
    parameter real         PG_FRAC    = PG_FRAC_DEFAULT,
    localparam int unsigned CH_W      = clog2_min1(NCH),
    localparam int unsigned S_W       = clog2_min1(RAMP_STEPS + 1),
    localparam int unsigned GAP_W     = clog2_min1(SEQ_GAP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  real             vset  [NCH],
    input  real             ilim  [NCH],
    input  real             rload [NCH],
    output real             VOUT  [NCH],
    output logic [NCH-1:0]  pgood,
    output logic            busy,
    output logic            fault,
    output logic [CH_W-1:0] cur_ch
);

    localparam logic [S_W-1:0]   LAST_UP  = S_W'(RAMP_STEPS - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SEQ_GAP - 1);

    seq_state_t       state;
    seq_state_t       state_nx;
    logic [CH_W-1:0]  ch_nx;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_nx;
    logic             busy_nx;
    logic             fault_nx;
    logic             inc_c;
    logic             dec_c;
    logic             clr_c;
    logic [NCH-1:0]   up_c;
    logic [NCH-1:0]   down_c;
    logic [NCH-1:0]   trip_c;
    logic [S_W-1:0]   step [NCH];
    logic [S_W-1:0]   cur_step_c;

    for (genvar i = 0; i < NCH; i++) begin : g_rail
        power_seq_rail #(
            .RAMP_STEPS (RAMP_STEPS),
            .RON        (RON),
            .ROFF       (ROFF),
            .PG_FRAC    (PG_FRAC)
        ) u_rail (
            .clk       (clk),
            .rst       (rst),
            .up        (up_c[i]),
            .down      (down_c[i]),
            .clr       (clr_c),
            .vset      (vset[i]),
            .ilim      (ilim[i]),
            .rload     (rload[i]),
            .vout      (VOUT[i]),
            .step      (step[i]),
            .pgood     (pgood[i]),
            .oc_trip_c (trip_c[i])
        );
    end

    assign cur_step_c = step[cur_ch];

    // Next-state logic; an overcurrent trip overrides every other transition.
    always_comb begin
        state_nx = state;
        ch_nx    = cur_ch;
        gap_nx   = gap_cnt;
        inc_c    = 1'b0;
        dec_c    = 1'b0;
        clr_c    = 1'b0;

        if (|trip_c) begin
            state_nx = FAULT;
            ch_nx    = '0;
            gap_nx   = '0;
            clr_c    = 1'b1;
        end else begin
            case (state)
                OFF: begin
                    if (en) begin
                        state_nx = RAMP_UP;
                        ch_nx    = '0;
                    end
                end
                RAMP_UP: begin
                    if (!en) begin
                        state_nx = RAMP_DN;
                    end else begin
                        inc_c = 1'b1;
                        if (cur_step_c >= LAST_UP) begin
                            if (cur_ch == LAST_CH) begin
                                state_nx = ON;
                            end else if (SEQ_GAP == 0) begin
                                ch_nx = cur_ch + CH_W'(1);
                            end else begin
                                state_nx = GAP;
                                gap_nx   = '0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (!en) begin
                        state_nx = RAMP_DN;
                    end else if (gap_cnt == GAP_LAST) begin
                        state_nx = RAMP_UP;
                        ch_nx    = cur_ch + CH_W'(1);
                        gap_nx   = '0;
                    end else begin
                        gap_nx = gap_cnt + GAP_W'(1);
                    end
                end
                ON: begin
                    if (!en) begin
                        state_nx = RAMP_DN;
                        ch_nx    = LAST_CH;
                    end
                end
                RAMP_DN: begin
                    dec_c = 1'b1;
                    if (cur_step_c <= S_W'(1)) begin
                        if (cur_ch == '0) begin
                            state_nx = OFF;
                        end else begin
                            ch_nx = cur_ch - CH_W'(1);
                        end
                    end
                end
                FAULT: begin
                    if (!en) begin
                        state_nx = OFF;
                    end
                end
                default: state_nx = OFF;
            endcase
        end

        busy_nx  = (state_nx == RAMP_UP) || (state_nx == GAP) || (state_nx == RAMP_DN);
        fault_nx = (state_nx == FAULT);

        for (int i = 0; i < NCH; i++) begin
            up_c[i]   = inc_c && (cur_ch == CH_W'(i));
            down_c[i] = dec_c && (cur_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF;
            cur_ch  <= '0;
            gap_cnt <= '0;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nx;
            cur_ch  <= ch_nx;
            gap_cnt <= gap_nx;
            busy    <= busy_nx;
            fault   <= fault_nx;
        end
    end

endmodule

// File: tb/tb_power_seq_adrive.sv
// Directed bench for power_seq_adrive: sequencing, abort, overcurrent filter,
// async reset and the zero-gap single-step configuration.
module tb_power_seq_adrive;

    localparam real RON  = 0.1;
    localparam real ROFF = 10e3;
    localparam real RL   = 1000.0;
    localparam real RSH  = 1.0;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a;
    logic       en_b;
    real        vset    [2];
    real        ilim    [2];
    real        rload_a [2];
    real        rload_b [2];
    real        vout_a  [2];
    real        vout_b  [2];
    logic [1:0] pgood_a;
    logic [1:0] pgood_b;
    logic       busy_a;
    logic       busy_b;
    logic       fault_a;
    logic       fault_b;
    logic [0:0] cur_ch_a;
    logic [0:0] cur_ch_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       shrt;
        int         s0;
        int         s1;
        logic [1:0] pg;
        logic       busy;
        logic       fault;
        logic       ch;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    power_seq_adrive #(.NCH(2), .RAMP_STEPS(4), .SEQ_GAP(2)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .en     (en_a),
        .vset   (vset),
        .ilim   (ilim),
        .rload  (rload_a),
        .VOUT   (vout_a),
        .pgood  (pgood_a),
        .busy   (busy_a),
        .fault  (fault_a),
        .cur_ch (cur_ch_a)
    );

    power_seq_adrive #(.NCH(2), .RAMP_STEPS(1), .SEQ_GAP(0)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .en     (en_b),
        .vset   (vset),
        .ilim   (ilim),
        .rload  (rload_b),
        .VOUT   (vout_b),
        .pgood  (pgood_b),
        .busy   (busy_b),
        .fault  (fault_b),
        .cur_ch (cur_ch_b)
    );

    // Expected node voltage of a ramped source into a resistive load.
    function automatic real vexp(input real vs, input int s, input int rs, input real rl);
        real vd;
        real r;
        vd = vs * real'(s) / real'(rs);
        r  = (s > 0) ? RON : ROFF;
        return vd * rl / (r + rl);
    endfunction

    task automatic chk_bits(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_real(input string name, input int idx, input real act, input real exp);
        checks++;
        if ((act - exp > 1e-6) || (exp - act > 1e-6)) begin
            errors++;
            $display("FAIL %s @%0d: got %f want %f", name, idx, act, exp);
        end
    endtask

    task automatic check_a(input int idx, input int s0, input int s1, input real rl1,
                           input logic [1:0] pg, input logic b, input logic f, input logic c);
        chk_real("a_vout0", idx, vout_a[0], vexp(1.8, s0, 4, RL));
        chk_real("a_vout1", idx, vout_a[1], vexp(0.9, s1, 4, rl1));
        chk_bits("a_pgood", idx, pgood_a, pg);
        chk_bits("a_busy",  idx, {1'b0, busy_a},  {1'b0, b});
        chk_bits("a_fault", idx, {1'b0, fault_a}, {1'b0, f});
        chk_bits("a_cur_ch", idx, {1'b0, cur_ch_a}, {1'b0, c});
    endtask

    task automatic check_b(input int idx, input int s0, input int s1,
                           input logic [1:0] pg, input logic b, input logic c);
        chk_real("b_vout0", idx, vout_b[0], vexp(1.8, s0, 1, RL));
        chk_real("b_vout1", idx, vout_b[1], vexp(0.9, s1, 1, RL));
        chk_bits("b_pgood", idx, pgood_b, pg);
        chk_bits("b_busy",  idx, {1'b0, busy_b},  {1'b0, b});
        chk_bits("b_fault", idx, {1'b0, fault_b}, 2'b00);
        chk_bits("b_cur_ch", idx, {1'b0, cur_ch_b}, {1'b0, c});
    endtask

    task automatic add(input logic e, input logic sh, input int s0, input int s1,
                       input logic [1:0] pg, input logic b, input logic f, input logic c);
        vec_t v;
        v.en = e; v.shrt = sh; v.s0 = s0; v.s1 = s1;
        v.pg = pg; v.busy = b; v.fault = f; v.ch = c;
        vecs.push_back(v);
    endtask

    // OFF to ON: rail 0 ramps, two gap cycles, rail 1 ramps, ON, pgood follows.
    task automatic add_powerup();
        add(1, 0, 0, 0, 2'b00, 1, 0, 0);
        add(1, 0, 1, 0, 2'b00, 1, 0, 0);
        add(1, 0, 2, 0, 2'b00, 1, 0, 0);
        add(1, 0, 3, 0, 2'b00, 1, 0, 0);
        add(1, 0, 4, 0, 2'b00, 1, 0, 0);
        add(1, 0, 4, 0, 2'b01, 1, 0, 0);
        add(1, 0, 4, 0, 2'b01, 1, 0, 1);
        add(1, 0, 4, 1, 2'b01, 1, 0, 1);
        add(1, 0, 4, 2, 2'b01, 1, 0, 1);
        add(1, 0, 4, 3, 2'b01, 1, 0, 1);
        add(1, 0, 4, 4, 2'b01, 0, 0, 1);
        add(1, 0, 4, 4, 2'b11, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ilim[i]    = 0.1;
            rload_a[i] = RL;
            rload_b[i] = RL;
        end
        vset[0] = 1.8;
        vset[1] = 0.9;

        repeat (2) @(posedge clk);
        #1;
        check_a(-1, 0, 0, RL, 2'b00, 0, 0, 0);
        rst = 1'b0;

        add_powerup();
        // One-cycle short is filtered, a two-cycle short trips the fault.
        add(1, 0, 4, 4, 2'b11, 0, 0, 1);
        add(1, 1, 4, 4, 2'b11, 0, 0, 1);
        add(1, 0, 4, 4, 2'b11, 0, 0, 1);
        add(1, 1, 4, 4, 2'b11, 0, 0, 1);
        add(1, 1, 0, 0, 2'b00, 0, 1, 0);
        add(1, 0, 0, 0, 2'b00, 0, 1, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0);
        add_powerup();
        // Reverse power-down; en rising mid-way is ignored until OFF.
        add(0, 0, 4, 4, 2'b11, 1, 0, 1);
        add(0, 0, 4, 3, 2'b01, 1, 0, 1);
        add(0, 0, 4, 2, 2'b01, 1, 0, 1);
        add(0, 0, 4, 1, 2'b01, 1, 0, 1);
        add(0, 0, 4, 0, 2'b01, 1, 0, 0);
        add(0, 0, 3, 0, 2'b00, 1, 0, 0);
        add(1, 0, 2, 0, 2'b00, 1, 0, 0);
        add(1, 0, 1, 0, 2'b00, 1, 0, 0);
        add(1, 0, 0, 0, 2'b00, 0, 0, 0);
        add(1, 0, 0, 0, 2'b00, 1, 0, 0);
        add(1, 0, 1, 0, 2'b00, 1, 0, 0);
        add(1, 0, 2, 0, 2'b00, 1, 0, 0);
        // Abort during RAMP_UP at step 2.
        add(0, 0, 2, 0, 2'b00, 1, 0, 0);
        add(0, 0, 1, 0, 2'b00, 1, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            en_a       = vecs[k].en;
            rload_a[1] = vecs[k].shrt ? RSH : RL;
            @(posedge clk);
            #1;
            check_a(k, vecs[k].s0, vecs[k].s1, vecs[k].shrt ? RSH : RL,
                    vecs[k].pg, vecs[k].busy, vecs[k].fault, vecs[k].ch);
        end

        // Asynchronous reset in the middle of the rail 0 ramp.
        en_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_a(100, 2, 0, RL, 2'b00, 1, 0, 0);
        rst = 1'b1;
        #1;
        check_a(101, 0, 0, RL, 2'b00, 0, 0, 0);
        en_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_a(102, 0, 0, RL, 2'b00, 0, 0, 0);

        // Zero gap, single-step ramp: rail 1 follows rail 0 immediately.
        en_b = 1'b1;
        @(posedge clk); #1; check_b(200, 0, 0, 2'b00, 1, 0);
        @(posedge clk); #1; check_b(201, 1, 0, 2'b00, 1, 1);
        @(posedge clk); #1; check_b(202, 1, 1, 2'b01, 0, 1);
        @(posedge clk); #1; check_b(203, 1, 1, 2'b11, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
